// File: rtl/dmaster_st_packet_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmaster_st_packet_arbiter_if
//
// Bundles the Avalon-ST signals around the packet arbiter: NUM_IN requester
// streams on the sink side and one tagged stream on the source side.
//
// Signals
//   in_valid / in_ready / in_startofpacket / in_endofpacket : NUM_IN bits, one per requester
//   in_data        : NUM_IN*DATA_W, requester i at [i*DATA_W +: DATA_W]
//   out_valid / out_ready / out_startofpacket / out_endofpacket : merged stream
//   out_data       : DATA_W
//   out_channel    : CHANNEL_W, index of the requester that sourced the beat
//
// Modports
//   master : the arbiter (it drives in_ready and the merged output stream)
//   slave  : the environment (requesters and the downstream adapter)
// ---------------------------------------------------------------------------
interface dmaster_st_packet_arbiter_if #(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_startofpacket;
    logic [NUM_IN-1:0]        in_endofpacket;

    logic                     out_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CHANNEL_W-1:0]     out_channel;
    logic                     out_startofpacket;
    logic                     out_endofpacket;

    modport master (
        input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_channel,
               out_startofpacket, out_endofpacket
    );

    modport slave (
        output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_channel,
               out_startofpacket, out_endofpacket
    );
endinterface

// File: rtl/dmaster_st_packet_arbiter.sv
// ---------------------------------------------------------------------------
// dmaster_st_packet_arbiter
//
// Packet-level round-robin arbiter sharing one Avalon-ST byte stream between
// NUM_IN requesters. A grant is held from the first beat of a packet until its
// end-of-packet beat is accepted, so packets never interleave. Each forwarded
// beat is tagged with the winning requester index on out_channel. The output
// is a single registered stage whose payload is held under backpressure.
//
// Ports
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   st       : stream interface (master modport), see the interface header
//   grant_id : current or last granted requester
//   busy     : high while a grant is held (LOCKED)
//   sop_err  : sticky, set when the first beat of a grant lacks SOP
// ---------------------------------------------------------------------------
module dmaster_st_packet_arbiter #(
    parameter  int NUM_IN    = 4,
    parameter  int DATA_W    = 8,
    parameter  int CHANNEL_W = 8,
    localparam int GW        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    dmaster_st_packet_arbiter_if.master  st,
    output logic [GW-1:0]                grant_id,
    output logic                         busy,
    output logic                         sop_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_reg;
    logic [GW-1:0]        grant_reg;
    logic [GW-1:0]        ptr_reg;
    logic                 first_beat_reg;
    logic                 sop_err_reg;

    logic                 out_valid_reg;
    logic [DATA_W-1:0]    out_data_reg;
    logic [CHANNEL_W-1:0] out_channel_reg;
    logic                 out_sop_reg;
    logic                 out_eop_reg;

    // ------------------------------------------------------------------
    // Round-robin search: rot_idx[k] is the requester k positions after the
    // priority pointer, so the lowest k with a valid request wins.
    // ------------------------------------------------------------------
    logic [GW-1:0] rot_idx [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_rot
            logic [GW:0] sum;
            assign sum = {1'b0, ptr_reg} + (GW+1)'(gi);
            assign rot_idx[gi] = (sum >= (GW+1)'(NUM_IN)) ?
                                 GW'(sum - (GW+1)'(NUM_IN)) : GW'(sum);
        end
    endgenerate

    logic          hit;
    logic [GW-1:0] win_idx;

    // Walk from the far end down so the nearest requester overwrites the rest.
    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (st.in_valid[rot_idx[i]]) begin
                hit     = 1'b1;
                win_idx = rot_idx[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Granted requester's beat and the handshake on it.
    // ------------------------------------------------------------------
    logic              sel_valid;
    logic              sel_sop;
    logic              sel_eop;
    logic [DATA_W-1:0] sel_data;
    logic              out_space;
    logic              accept;

    assign sel_valid = st.in_valid[grant_reg];
    assign sel_sop   = st.in_startofpacket[grant_reg];
    assign sel_eop   = st.in_endofpacket[grant_reg];
    assign sel_data  = st.in_data[grant_reg*DATA_W +: DATA_W];

    // The output register can take a beat when empty or being drained now.
    assign out_space = !out_valid_reg || st.out_ready;
    assign accept    = (state_reg == LOCKED) && sel_valid && out_space;

    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_ready
            assign st.in_ready[gi] = (state_reg == LOCKED) &&
                                     (grant_reg == GW'(gi)) && out_space;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Grant FSM and output register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            ptr_reg         <= '0;
            first_beat_reg  <= 1'b0;
            sop_err_reg     <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_channel_reg <= '0;
            out_sop_reg     <= 1'b0;
            out_eop_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        grant_reg      <= win_idx;
                        first_beat_reg <= 1'b1;
                        state_reg      <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        first_beat_reg <= 1'b0;
                        // A malformed packet is still forwarded; only flagged.
                        if (first_beat_reg && !sel_sop) begin
                            sop_err_reg <= 1'b1;
                        end
                        // Only EOP releases the grant; a stray SOP does not.
                        if (sel_eop) begin
                            ptr_reg   <= (grant_reg == GW'(NUM_IN - 1)) ?
                                         '0 : grant_reg + 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (accept) begin
                out_valid_reg   <= 1'b1;
                out_data_reg    <= sel_data;
                out_sop_reg     <= sel_sop;
                out_eop_reg     <= sel_eop;
                out_channel_reg <= CHANNEL_W'(grant_reg);
            end else if (st.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign st.out_valid         = out_valid_reg;
    assign st.out_data          = out_data_reg;
    assign st.out_channel       = out_channel_reg;
    assign st.out_startofpacket = out_sop_reg;
    assign st.out_endofpacket   = out_eop_reg;

    assign grant_id = grant_reg;
    assign busy     = (state_reg == LOCKED);
    assign sop_err  = sop_err_reg;

endmodule

// File: tb/tb_dmaster_st_packet_arbiter.sv
module tb_dmaster_st_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmaster_st_packet_arbiter_if #(.NUM_IN(N), .DATA_W(DW), .CHANNEL_W(CW)) bus();

    logic [1:0] grant_id;
    logic       busy;
    logic       sop_err;

    dmaster_st_packet_arbiter #(.NUM_IN(N), .DATA_W(DW), .CHANNEL_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .st       (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .sop_err  (sop_err)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Packet source queues, behavioural model and output log
    // ------------------------------------------------------------------
    typedef struct { logic [7:0] data; logic sop; logic eop; } beat_t;
    typedef struct { logic [7:0] data; logic sop; logic eop; logic [7:0] ch; int cyc; } obs_t;

    beat_t req_q [N][$];
    int    plen_q[N][$];
    obs_t  exp_q[$];
    obs_t  log_q[$];
    int    rdy_pat[$];
    int    model_ptr = 0;
    int    stall_cycles;

    task automatic add_packet(input int r, input int len, input logic [7:0] base, input bit bad_sop);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + 8'(k);
            b.sop  = (k == 0) ? !bad_sop : 1'b0;
            b.eop  = (k == len - 1);
            req_q[r].push_back(b);
        end
        plen_q[r].push_back(len);
    endtask

    // Packet-level model: every requester with packets left is requesting at
    // each arbitration point, so the order is plain round robin over them.
    task automatic build_expected();
        beat_t tmp[N][$];
        int    lens[N][$];
        int    found, len, r;
        beat_t b;
        obs_t  o;
        for (int i = 0; i < N; i++) begin
            tmp[i]  = req_q[i];
            lens[i] = plen_q[i];
            plen_q[i].delete();
        end
        exp_q.delete();
        while (1) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                r = (model_ptr + k) % N;
                if (found < 0 && lens[r].size() > 0) found = r;
            end
            if (found < 0) break;
            len = lens[found].pop_front();
            for (int k = 0; k < len; k++) begin
                b = tmp[found].pop_front();
                o.data = b.data; o.sop = b.sop; o.eop = b.eop; o.ch = 8'(found); o.cyc = 0;
                exp_q.push_back(o);
            end
            model_ptr = (found + 1) % N;
        end
    endtask

    // Drives all queued packets, logs every output handshake and checks the
    // handshake invariants each cycle. Entered and left at posedge + 1.
    task automatic run_engine(input string tag, input int max_cyc, input int rdy_mode, input int drop_pct);
        logic [N-1:0]    v, s, e, acc, mid;
        logic [N*DW-1:0] d;
        logic [18:0]     snap, prev_snap;
        logic            prev_stall, all_empty;
        int              cyc, viol, nmin;
        bit              done, timed_out;
        beat_t           b;
        obs_t            o;
        build_expected();
        log_q.delete();
        mid = '0; prev_stall = 1'b0; prev_snap = '0;
        cyc = 0; viol = 0; done = 0; timed_out = 0; stall_cycles = 0;
        while (!done) begin
            v = '0; s = '0; e = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                if (req_q[i].size() > 0) begin
                    v[i] = 1'b1;
                    if (mid[i] && ($urandom_range(99) < drop_pct)) v[i] = 1'b0;
                    d[i*DW +: DW] = req_q[i][0].data;
                    s[i] = req_q[i][0].sop;
                    e[i] = req_q[i][0].eop;
                end
            end
            bus.in_valid = v; bus.in_data = d;
            bus.in_startofpacket = s; bus.in_endofpacket = e;
            if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(1));
            else if (rdy_mode == 2 && cyc < rdy_pat.size()) bus.out_ready = 1'(rdy_pat[cyc]);
            else bus.out_ready = 1'b1;

            @(negedge clk);
            acc = bus.in_valid & bus.in_ready;
            if ($countones(bus.in_ready) > 1) viol++;
            if (bus.out_valid && !bus.out_ready && bus.in_ready != '0) viol++;
            snap = {bus.out_valid, bus.out_data, bus.out_startofpacket,
                    bus.out_endofpacket, bus.out_channel};
            if (prev_stall && snap != prev_snap) viol++;
            prev_stall = bus.out_valid && !bus.out_ready;
            if (prev_stall) stall_cycles++;
            prev_snap = snap;
            if (bus.out_valid && bus.out_ready) begin
                o.data = bus.out_data; o.sop = bus.out_startofpacket;
                o.eop = bus.out_endofpacket; o.ch = bus.out_channel; o.cyc = cyc;
                log_q.push_back(o);
            end

            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    b = req_q[i].pop_front();
                    mid[i] = !b.eop;
                end
            end
            cyc++;
            all_empty = 1'b1;
            for (int i = 0; i < N; i++) if (req_q[i].size() > 0) all_empty = 1'b0;
            if (all_empty && !bus.out_valid) done = 1;
            else if (cyc >= max_cyc) begin done = 1; timed_out = 1; end
        end
        check({tag, " timeout"}, 64'(timed_out), 64'd0);
        check({tag, " beat count"}, 64'(log_q.size()), 64'(exp_q.size()));
        nmin = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int k = 0; k < nmin; k++)
            check($sformatf("%s beat%0d {data,sop,eop,ch}", tag, k),
                  {46'd0, log_q[k].data, log_q[k].sop, log_q[k].eop, log_q[k].ch},
                  {46'd0, exp_q[k].data, exp_q[k].sop, exp_q[k].eop, exp_q[k].ch});
        check({tag, " handshake violations"}, 64'(viol), 64'd0);
        for (int i = 0; i < N; i++) req_q[i].delete();
    endtask

    // With out_ready high and no valid gaps: back-to-back inside a packet,
    // exactly one bubble after each EOP.
    task automatic check_gaps(input string tag);
        int bad = 0;
        for (int k = 1; k < log_q.size(); k++)
            if (log_q[k].cyc - log_q[k-1].cyc != (log_q[k-1].eop ? 2 : 1)) bad++;
        check({tag, " gap errors"}, 64'(bad), 64'd0);
    endtask

    task automatic drive_idle();
        bus.in_valid = '0; bus.in_data = '0;
        bus.in_startofpacket = '0; bus.in_endofpacket = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_ptr = 0;
    endtask

    // ------------------------------------------------------------------
    // Cycle table: 3-beat packet on input 2, then inputs 0 and 3 together
    // (pointer is 3 after the first packet, so input 3 must win).
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] v; logic [31:0] d; logic [3:0] s; logic [3:0] e; logic ordy;
        logic ov; logic [7:0] od; logic os; logic oe; logic [7:0] och;
        logic [3:0] ir; logic bsy; logic [1:0] gid;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] a_vec, e_vec;
        tbl[0] = '{4'b0100, 32'h0011_0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 4'b0000, 1'b0, 2'd0};
        tbl[1] = '{4'b0100, 32'h0011_0000, 4'b0100, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 4'b0100, 1'b1, 2'd2};
        tbl[2] = '{4'b0100, 32'h0022_0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'd2, 4'b0100, 1'b1, 2'd2};
        tbl[3] = '{4'b0100, 32'h0033_0000, 4'b0000, 4'b0100, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'd2, 4'b0100, 1'b1, 2'd2};
        tbl[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 8'd2, 4'b0000, 1'b0, 2'd2};
        tbl[5] = '{4'b1001, 32'h3A00_000A, 4'b1001, 4'b1001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 4'b0000, 1'b0, 2'd2};
        tbl[6] = '{4'b1001, 32'h3A00_000A, 4'b1001, 4'b1001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 4'b1000, 1'b1, 2'd3};
        tbl[7] = '{4'b0001, 32'h0000_000A, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h3A, 1'b1, 1'b1, 8'd3, 4'b0000, 1'b0, 2'd3};
        tbl[8] = '{4'b0001, 32'h0000_000A, 4'b0001, 4'b0001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 4'b0001, 1'b1, 2'd0};
        tbl[9] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b1, 8'd0, 4'b0000, 1'b0, 2'd0};

        do_reset();
        @(negedge clk);
        check("reset state", {44'd0, bus.out_valid, bus.out_data, bus.out_channel,
                              bus.out_startofpacket, bus.out_endofpacket, grant_id, busy, sop_err},
              64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;

        // table-driven cycles
        for (int r = 0; r < 10; r++) begin
            bus.in_valid = tbl[r].v; bus.in_data = tbl[r].d;
            bus.in_startofpacket = tbl[r].s; bus.in_endofpacket = tbl[r].e;
            bus.out_ready = tbl[r].ordy;
            @(negedge clk);
            a_vec = {bus.out_valid, bus.out_valid ? {bus.out_data, bus.out_startofpacket,
                     bus.out_endofpacket, bus.out_channel} : 18'd0, bus.in_ready, busy, grant_id};
            e_vec = {tbl[r].ov, tbl[r].ov ? {tbl[r].od, tbl[r].os, tbl[r].oe, tbl[r].och} : 18'd0,
                     tbl[r].ir, tbl[r].bsy, tbl[r].gid};
            check($sformatf("table row%0d {ov,payload,in_ready,busy,grant}", r), 64'(a_vec), 64'(e_vec));
            @(posedge clk); #1;
        end
        drive_idle();
        @(posedge clk); #1;

        // four requesters continuously valid, two 2-beat packets each
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++) add_packet(r, 2, 8'(8'h10 * r + 8'h02 * p), 0);
        run_engine("rr4", 200, 0, 0);
        check_gaps("rr4");

        // backpressure 1,0,0,1 in the middle of a 4-beat packet
        do_reset();
        rdy_pat = '{1, 1, 1, 0, 0, 1};
        add_packet(1, 4, 8'h80, 0);
        run_engine("stall", 100, 2, 0);
        check("stall cycles seen", 64'(stall_cycles), 64'd2);

        // simultaneous single-beat packets on inputs 0 and 1
        do_reset();
        add_packet(0, 1, 8'hA0, 0);
        add_packet(1, 1, 8'hB0, 0);
        run_engine("single", 100, 0, 0);
        check_gaps("single");

        // reset in the middle of a 5-beat packet on input 3 (pointer is 2 here)
        add_packet(1, 1, 8'hC0, 0);
        run_engine("pre_rst", 100, 0, 0);
        bus.in_valid = 4'b1000; bus.in_data = 32'h5100_0000;
        bus.in_startofpacket = 4'b1000; bus.in_endofpacket = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_data = 32'h5200_0000; bus.in_startofpacket = 4'b0000;
        @(posedge clk); #1;
        bus.in_data = 32'h5300_0000;
        check("before reset {ov,data,ch}", {47'd0, bus.out_valid, bus.out_data, bus.out_channel},
              {47'd0, 1'b1, 8'h52, 8'd3});
        reset_n = 1'b0;
        #1;
        check("async reset outputs", {40'd0, bus.out_valid, bus.out_data, bus.out_channel,
                                      bus.out_startofpacket, bus.out_endofpacket, bus.in_ready,
                                      grant_id, busy, sop_err}, 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_ptr = 0;
        bus.in_valid = 4'b1001; bus.in_data = 32'h3100_000A;
        bus.in_startofpacket = 4'b1001; bus.in_endofpacket = 4'b0001;
        @(posedge clk); #1;
        check("post-reset winner {busy,grant}", {61'd0, busy, grant_id}, {61'd0, 1'b1, 2'd0});
        drive_idle();

        // missing SOP on input 1: forwarded, sticky flag until reset
        do_reset();
        check("sop_err clear", 64'(sop_err), 64'd0);
        add_packet(1, 2, 8'h40, 1);
        add_packet(0, 2, 8'h50, 0);
        add_packet(2, 1, 8'h60, 0);
        run_engine("soperr", 200, 0, 0);
        check("sop_err set", 64'(sop_err), 64'd1);
        add_packet(3, 2, 8'h70, 0);
        add_packet(1, 3, 8'h78, 0);
        run_engine("soperr_clean", 200, 0, 0);
        check("sop_err sticky", 64'(sop_err), 64'd1);
        do_reset();
        check("sop_err after reset", 64'(sop_err), 64'd0);

        // randomized traffic against the round-robin model
        for (int round = 0; round < 15; round++) begin
            do_reset();
            for (int r = 0; r < N; r++) begin
                int npk;
                npk = $urandom_range(3);
                for (int p = 0; p < npk; p++)
                    add_packet(r, $urandom_range(1, 5), 8'($urandom), 0);
            end
            run_engine($sformatf("rand%0d", round), 3000, 1, 30);
            check($sformatf("rand%0d sop_err", round), 64'(sop_err), 64'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
